// File: rtl/mem_dma_pkg.sv
// Shared definitions for the DMA memory responder: command encodings,
// FIFO depths and the response word layout.
package mem_dma_pkg;

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam int CMD_FIFO_DEPTH = 4;
  localparam int RSP_FIFO_DEPTH = 4;

  localparam int RSP_DATA_W = 32;
  localparam int RSP_TAG_W  = 4;

  // Response word at default widths; the responder packs its
  // response FIFO entries in this same {data, tag, err} order.
  typedef struct packed {
    logic [RSP_DATA_W-1:0] data;
    logic [RSP_TAG_W-1:0]  tag;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/mem_dma_fifo.sv
// Small synchronous FIFO used for both the command and response queues.
// Ports: clk, rst (sync, active-high), push_i/din_i, pop_i/dout_o,
// full_o, empty_o, count_o (0..DEPTH). Push on full and pop on empty
// are ignored.
module mem_dma_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = do_push ? nxt(wr_q) : wr_q;
    rd_d  = do_pop ? nxt(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/mem_dma_responder.sv
// DMA-facing memory responder: queues requests, issues them to a
// 1-cycle-latency SRAM and returns in-order responses.
// Ports: clk, reset_poweron (sync, active-high); request handshake
// dma2mem_valid/ready with cmd/addr/wdata/tag; response handshake
// mem2dma_valid/ready with data/tag/err; SRAM en/we/addr/wdata/rdata.
// Build option: MEM_DMA_RESPONDER_WR_ACK_EN adds a response per WRITE.
module mem_dma_responder
  import mem_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  dma2mem_valid,
  output logic                  dma2mem_ready,
  input  logic [1:0]            dma2mem_cmd,
  input  logic [ADDR_WIDTH-1:0] dma2mem_addr,
  input  logic [DATA_WIDTH-1:0] dma2mem_wdata,
  input  logic [TAG_WIDTH-1:0]  dma2mem_tag,
  output logic                  mem2dma_valid,
  input  logic                  mem2dma_ready,
  output logic [DATA_WIDTH-1:0] mem2dma_data,
  output logic [TAG_WIDTH-1:0]  mem2dma_tag,
  output logic                  mem2dma_err,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int CQW = 2 + ADDR_WIDTH + DATA_WIDTH + TAG_WIDTH;
  localparam int RQW = DATA_WIDTH + TAG_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [CQW-1:0] cq_dout;
  logic           cq_full, cq_empty, cmd_push;
  logic [2:0]     cq_cnt;

  logic [RQW-1:0] rq_din, rq_dout;
  logic           rq_full, rq_empty, rsp_pop;
  logic [2:0]     rq_cnt;

  logic [1:0]            h_cmd;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic [TAG_WIDTH-1:0]  h_tag;
  logic                  is_rd, is_wr, in_rng, credit_ok, issue;

  // One-deep stage between issue and response push; it lines the
  // response up with sram_rdata and keeps every response in order.
  logic                 pend_q, pend_d;
  logic                 pend_rd_q, pend_rd_d;
  logic                 pend_err_q, pend_err_d;
  logic [TAG_WIDTH-1:0] pend_tag_q, pend_tag_d;

  assign cmd_push      = dma2mem_valid && !cq_full && !reset_poweron;
  assign dma2mem_ready = !reset_poweron && (cq_cnt < 3'(CMD_FIFO_DEPTH));

  mem_dma_fifo #(.WIDTH(CQW), .DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
    .clk    (clk),
    .rst    (reset_poweron),
    .push_i (cmd_push),
    .din_i  ({dma2mem_cmd, dma2mem_addr, dma2mem_wdata, dma2mem_tag}),
    .pop_i  (issue),
    .dout_o (cq_dout),
    .full_o (cq_full),
    .empty_o(cq_empty),
    .count_o(cq_cnt)
  );

  assign {h_cmd, h_addr, h_wdata, h_tag} = cq_dout;
  assign is_rd  = (h_cmd == CMD_READ);
  assign is_wr  = (h_cmd == CMD_WRITE);
  assign in_rng = ({1'b0, h_addr} < DEPTH_L);

  // The in-flight slot counts against the response FIFO so a pushed
  // response always finds room.
  assign credit_ok = !rq_full &&
                     ((3'(pend_q) + rq_cnt) < 3'(RSP_FIFO_DEPTH));
  assign issue = !reset_poweron && !cq_empty && credit_ok;

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    pend_d     = 1'b0;
    pend_rd_d  = 1'b0;
    pend_err_d = 1'b0;
    pend_tag_d = h_tag;
    if (issue) begin
      unique case (1'b1)
        is_rd && in_rng: begin
          sram_en   = 1'b1;
          sram_addr = h_addr;
          pend_d    = 1'b1;
          pend_rd_d = 1'b1;
        end
        is_wr && in_rng: begin
          sram_en    = 1'b1;
          sram_we    = 1'b1;
          sram_addr  = h_addr;
          sram_wdata = h_wdata;
`ifdef MEM_DMA_RESPONDER_WR_ACK_EN
          pend_d     = 1'b1;
`endif
        end
        is_wr && !in_rng: begin
`ifdef MEM_DMA_RESPONDER_WR_ACK_EN
          pend_d     = 1'b1;
          pend_err_d = 1'b1;
`endif
        end
        default: begin
          pend_d     = 1'b1;
          pend_err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      pend_q     <= 1'b0;
      pend_rd_q  <= 1'b0;
      pend_err_q <= 1'b0;
      pend_tag_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_rd_q  <= pend_rd_d;
      pend_err_q <= pend_err_d;
      pend_tag_q <= pend_tag_d;
    end
  end

  assign rq_din = {pend_rd_q ? sram_rdata : '0, pend_tag_q, pend_err_q};
  assign rsp_pop = mem2dma_valid && mem2dma_ready;

  mem_dma_fifo #(.WIDTH(RQW), .DEPTH(RSP_FIFO_DEPTH)) u_rsp_fifo (
    .clk    (clk),
    .rst    (reset_poweron),
    .push_i (pend_q),
    .din_i  (rq_din),
    .pop_i  (rsp_pop),
    .dout_o (rq_dout),
    .full_o (rq_full),
    .empty_o(rq_empty),
    .count_o(rq_cnt)
  );

  assign mem2dma_valid = !reset_poweron && !rq_empty;
  assign {mem2dma_data, mem2dma_tag, mem2dma_err} =
    mem2dma_valid ? rq_dout : '0;

endmodule

// File: tb/tb_mem_dma_responder.sv
// Directed + random bench for mem_dma_responder with an SRAM model
// and an in-order expected-response queue.
module tb_mem_dma_responder;

  localparam int MEM_DEPTH = 4096;
`ifdef MEM_DMA_RESPONDER_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  logic        clk;
  logic        reset_poweron;
  logic        dma2mem_valid, dma2mem_ready;
  logic [1:0]  dma2mem_cmd;
  logic [23:0] dma2mem_addr;
  logic [31:0] dma2mem_wdata;
  logic [3:0]  dma2mem_tag;
  logic        mem2dma_valid, mem2dma_ready;
  logic [31:0] mem2dma_data;
  logic [3:0]  mem2dma_tag;
  logic        mem2dma_err;
  logic        sram_en, sram_we;
  logic [23:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  logic rnd_rdy, rnd_r, rdy_man, load_mem, lat_chk;
  assign mem2dma_ready = rnd_rdy ? rnd_r : rdy_man;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc_n = 0;
  int rsp_n = 0;
  int en_cnt = 0;

  logic [31:0] sram   [MEM_DEPTH];
  logic [31:0] shadow [MEM_DEPTH];
  logic [36:0] expq [$];

  mem_dma_responder #(
    .ADDR_WIDTH(24), .DATA_WIDTH(32), .TAG_WIDTH(4), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clk(clk), .reset_poweron(reset_poweron),
    .dma2mem_valid(dma2mem_valid), .dma2mem_ready(dma2mem_ready),
    .dma2mem_cmd(dma2mem_cmd), .dma2mem_addr(dma2mem_addr),
    .dma2mem_wdata(dma2mem_wdata), .dma2mem_tag(dma2mem_tag),
    .mem2dma_valid(mem2dma_valid), .mem2dma_ready(mem2dma_ready),
    .mem2dma_data(mem2dma_data), .mem2dma_tag(mem2dma_tag),
    .mem2dma_err(mem2dma_err),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < MEM_DEPTH; i++) sram[i] <= shadow[i];
    end else if (sram_en && sram_addr < MEM_DEPTH) begin
      if (sram_we) sram[sram_addr[11:0]] <= sram_wdata;
      else sram_rdata <= sram[sram_addr[11:0]];
    end
  end

  initial begin
    rnd_r = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rnd_r = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", nm, obs, exp);
    end
  endtask

  // Reference: each accepted request yields its response (if any) in
  // acceptance order; reads see every earlier write.
  task automatic model_accept(input logic [1:0] c, input logic [23:0] a,
                              input logic [31:0] d, input logic [3:0] t);
    logic inr;
    inr = (a < MEM_DEPTH);
    acc_cyc = cyc;
    acc_n++;
    if (c == 2'b01) begin
      if (inr) expq.push_back({shadow[a[11:0]], t, 1'b0});
      else expq.push_back({32'h0, t, 1'b1});
    end else if (c == 2'b10) begin
      if (inr) shadow[a[11:0]] = d;
      if (WR_ACK) expq.push_back({32'h0, t, !inr});
    end else begin
      expq.push_back({32'h0, t, 1'b1});
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [23:0] a,
                      input logic [31:0] d, input logic [3:0] t);
    logic got;
    got = 1'b0;
    dma2mem_valid = 1'b1;
    dma2mem_cmd   = c;
    dma2mem_addr  = a;
    dma2mem_wdata = d;
    dma2mem_tag   = t;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (dma2mem_ready) begin
        got = 1'b1;
        model_accept(c, a, d, t);
      end
    end
    chk("accept", got, 1);
    @(posedge clk);
    #1;
    dma2mem_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    rnd_rdy = 1'b0;
    rdy_man = 1'b1;
    for (int k = 0; k < 300 && expq.size() != 0; k++) @(posedge clk);
    #1;
    chk({nm, "_drain"}, expq.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_a"}, {dma2mem_ready, mem2dma_valid, mem2dma_data,
                     mem2dma_tag, mem2dma_err, sram_en, sram_we}, 0);
    chk({nm, "_b"}, {sram_addr, sram_wdata}, 0);
  endtask

  logic        seen_v = 1'b0;
  logic        hold_chk = 1'b0;
  logic [36:0] held;

  always @(negedge clk) begin
    if (reset_poweron) begin
      seen_v   = 1'b0;
      hold_chk = 1'b0;
    end else begin
      if (sram_en) begin
        en_cnt++;
        chk("sram_in_range", sram_addr < MEM_DEPTH, 1);
      end
      if (hold_chk && mem2dma_valid)
        chk("rsp_stable", {mem2dma_data, mem2dma_tag, mem2dma_err}, held);
      hold_chk = mem2dma_valid && !mem2dma_ready;
      held = {mem2dma_data, mem2dma_tag, mem2dma_err};
      if (lat_chk && mem2dma_valid && !seen_v) begin
        chk("latency", cyc - acc_cyc, 3);
        lat_chk = 1'b0;
      end
      seen_v = mem2dma_valid;
      if (mem2dma_valid && mem2dma_ready) begin
        rsp_n++;
        chk("rsp_expected", expq.size() != 0, 1);
        if (expq.size() != 0)
          chk("rsp", {mem2dma_data, mem2dma_tag, mem2dma_err},
              expq.pop_front());
      end
    end
  end

  int b_acc, b_rsp, b_en;
  logic [1:0]  rc;
  logic [23:0] ra;

  initial begin
    reset_poweron = 1'b1;
    dma2mem_valid = 1'b0;
    dma2mem_cmd   = '0;
    dma2mem_addr  = '0;
    dma2mem_wdata = '0;
    dma2mem_tag   = '0;
    rdy_man  = 1'b1;
    rnd_rdy  = 1'b0;
    lat_chk  = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) shadow[i] = $urandom;
    shadow[16] = 32'hDEADBEEF;
    load_mem = 1'b1;
    @(posedge clk);
    #1;
    load_mem = 1'b0;
    @(negedge clk);
    check_zero("reset_out");
    @(posedge clk);
    #1;
    reset_poweron = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", dma2mem_ready, 1);
    @(posedge clk);
    #1;

    // single read, empty pipeline
    lat_chk = 1'b1;
    send(2'b01, 24'h10, 32'h0, 4'd3);
    drain("rd_basic");
    chk("rd_basic_lat_seen", lat_chk, 0);

    // write then read back
    b_rsp = rsp_n;
    send(2'b10, 24'd5, 32'h1234, 4'd6);
    send(2'b01, 24'd5, 32'h0, 4'd7);
    drain("wr_rd");
    chk("wr_rd_count", rsp_n - b_rsp, WR_ACK ? 2 : 1);

    // backpressure: 8 accepts then full
    rdy_man = 1'b0;
    b_acc = acc_n;
    b_rsp = rsp_n;
    for (int i = 0; i < 8; i++)
      send(2'b01, 24'($urandom_range(0, MEM_DEPTH - 1)), 32'h0, i[3:0]);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_accepts", acc_n - b_acc, 8);
    chk("bp_ready_low", dma2mem_ready, 0);
    chk("bp_no_rsp", rsp_n - b_rsp, 0);
    chk("bp_valid", mem2dma_valid, 1);
    chk("bp_head_tag", mem2dma_tag, 0);
    rdy_man = 1'b1;
    for (int i = 8; i < 10; i++)
      send(2'b01, 24'($urandom_range(0, MEM_DEPTH - 1)), 32'h0, i[3:0]);
    drain("bp");
    chk("bp_rsp_count", rsp_n - b_rsp, 10);

    // out-of-range read and illegal command
    b_en = en_cnt;
    b_rsp = rsp_n;
    send(2'b01, 24'(MEM_DEPTH), 32'h0, 4'd2);
    send(2'b00, 24'h20, 32'h0, 4'd9);
    drain("err");
    chk("err_no_sram", en_cnt - b_en, 0);
    chk("err_rsp_count", rsp_n - b_rsp, 2);

    // reset with pending responses
    rdy_man = 1'b0;
    for (int i = 1; i < 4; i++)
      send(2'b01, 24'($urandom_range(0, MEM_DEPTH - 1)), 32'h0, i[3:0]);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_pending_valid", mem2dma_valid, 1);
    reset_poweron = 1'b1;
    expq.delete();
    @(negedge clk);
    check_zero("rst_mid");
    @(posedge clk);
    #1;
    reset_poweron = 1'b0;
    @(negedge clk);
    chk("rst_ready_back", dma2mem_ready, 1);
    chk("rst_valid_low", mem2dma_valid, 0);
    @(posedge clk);
    #1;
    rdy_man = 1'b1;
    b_rsp = rsp_n;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_stale", rsp_n - b_rsp, 0);
    lat_chk = 1'b1;
    send(2'b01, 24'h10, 32'h0, 4'd5);
    drain("rst_rd");
    chk("rst_rd_lat_seen", lat_chk, 0);

    // random traffic with random response backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        ra = 24'(MEM_DEPTH + $urandom_range(0, 50));
      else
        ra = 24'($urandom_range(0, 15));
      send(rc, ra, $urandom, 4'($urandom_range(0, 15)));
    end
    drain("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_dma_responder.md
MEM_DMA_RESPONDER -- requirements
Module: mem_dma_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24, request address width in words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter TAG_WIDTH, default 4, request/response tag width.
REQ-004 SHALL have parameter MEM_DEPTH, default 4096, number of valid words; addresses >= MEM_DEPTH are out of range.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_poweron  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports dma2mem_valid  input  1 and dma2mem_ready  output  1, the request handshake.
REQ-008 SHALL have ports dma2mem_cmd  input  2, dma2mem_addr  input  ADDR_WIDTH, dma2mem_wdata  input  DATA_WIDTH and dma2mem_tag  input  TAG_WIDTH, the request payload.
REQ-009 SHALL have ports mem2dma_valid  output  1 and mem2dma_ready  input  1, the response handshake.
REQ-010 SHALL have ports mem2dma_data  output  DATA_WIDTH, mem2dma_tag  output  TAG_WIDTH and mem2dma_err  output  1, the response payload.
REQ-011 SHALL have SRAM ports sram_en  output  1, sram_we  output  1, sram_addr  output  ADDR_WIDTH, sram_wdata  output  DATA_WIDTH and sram_rdata  input  DATA_WIDTH; sram_rdata is valid one cycle after sram_en with sram_we=0.

Function
REQ-012 SHALL accept a request only on a cycle with dma2mem_valid=1 and dma2mem_ready=1, pushing it into a 4-entry command FIFO.
REQ-013 SHALL drive dma2mem_ready = command FIFO not full; when full, ready=0 and payload is ignored; no push-on-full.
REQ-014 SHALL decode cmd as 01=READ, 10=WRITE; 00 and 11 are ILLEGAL.
REQ-015 SHALL pop and issue the head command in one cycle only when credits allow: outstanding reads plus response-FIFO occupancy < 4 (response FIFO depth 4).
REQ-016 SHALL issue an in-range READ as sram_en=1, sram_we=0, and push {sram_rdata, tag, err=0} into the response FIFO on the following cycle.
REQ-017 SHALL issue an in-range WRITE as sram_en=1, sram_we=1, sram_wdata=payload, producing no response (see REQ-026).
REQ-018 SHALL NOT access SRAM for an out-of-range READ or an ILLEGAL command; it SHALL push {data=0, tag, err=1}, consuming one credit.
REQ-019 SHALL drop an out-of-range WRITE silently, with no SRAM access and no response.
REQ-020 SHALL return responses strictly in request-acceptance order.
REQ-021 SHALL present the response FIFO head on mem2dma_*; mem2dma_valid = FIFO not empty; pop on valid and ready; payload SHALL hold stable while valid=1 and ready=0.
REQ-022 SHALL achieve, with empty pipeline, for a READ accepted at cycle T: issue at T+1, FIFO push at T+2, mem2dma_valid=1 at T+3.
REQ-023 SHALL allow simultaneous push and pop on both FIFOs in the same cycle; occupancy stays unchanged.
REQ-024 SHALL wrap FIFO pointers modulo depth; occupancy counters SHALL be 3 bits wide (0..4).

Reset
REQ-025 SHALL, while reset_poweron=1, clear both FIFOs, outstanding-read and credit counters, drop in-flight SRAM reads, and drive dma2mem_ready=0, mem2dma_valid=0, mem2dma_data=0, mem2dma_tag=0, mem2dma_err=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0; ready SHALL rise the first cycle after reset deasserts, and reset mid-transfer SHALL discard all pending responses.

Configuration
REQ-026 SHALL, with macro MEM_DMA_RESPONDER_WR_ACK_EN defined, push a response {data=0, tag, err=0} for each in-range WRITE at issue+1, consuming one credit, and an err=1 response for out-of-range WRITEs; without it, writes SHALL follow REQ-017/REQ-019.

Structure
REQ-027 SHALL place cmd encodings (CMD_READ, CMD_WRITE), FIFO depth constants and the response struct typedef in shared package mem_dma_pkg.
REQ-028 SHALL implement both FIFOs as two instances of one sub-module mem_dma_fifo (parameterised width/depth, push/pop/full/empty/count).

Verification
REQ-029 SHALL cover: READ addr=0x10 tag=3 with SRAM[0x10]=0xDEADBEEF, mem2dma_ready=1 -> valid at T+3, data=0xDEADBEEF, tag=3, err=0.
REQ-030 SHALL cover: WRITE addr=5 data=0x1234 then READ addr=5 tag=7 -> response data=0x1234, tag=7; response count 1 (2 with WR_ACK_EN, ack first).
REQ-031 SHALL cover: mem2dma_ready=0 while issuing 10 back-to-back READs -> at most 4 responses buffered, dma2mem_ready=0 after 8 accepts, no loss; release ready -> 10 in-order responses, tags 0..9.
REQ-032 SHALL cover: READ addr=MEM_DEPTH tag=2 and cmd=00 tag=9 -> no sram_en, responses err=1 data=0 with tags 2 then 9.
REQ-033 SHALL cover: reset_poweron asserted for 1 cycle with 3 responses pending -> all outputs 0, no stale responses after reset, next READ returns correct data.
